// File: rtl/bmem_arbiter_pkg.sv
// Shared constants and types for the banked-memory arbiter and its line collectors.
package bmem_arb_pkg;
   localparam int BEAT_WIDTH  = 64;
   localparam int BURST_LEN   = 4;
   localparam int LINE_WIDTH  = BEAT_WIDTH * BURST_LEN;
   localparam int OFFSET_BITS = 5;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      WBURST = 1'b1
   } arb_state_t;

   typedef logic [LINE_WIDTH-1:0] line_t;
endpackage

// File: rtl/bmem_arbiter_if.sv
// Banked-memory pin bundle: command/write-beat channel out, read-beat return channel in.
// Handshake: a command or write beat is transferred in a cycle where (bmem_read|bmem_write) && bmem_ready;
// returning beats are qualified by bmem_rvalid alone (no back-pressure) and tagged with bmem_raddr.
interface bmem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int BEAT_WIDTH = 64
);
   logic [ADDR_WIDTH-1:0] bmem_addr;
   logic                  bmem_read;
   logic                  bmem_write;
   logic [BEAT_WIDTH-1:0] bmem_wdata;
   logic                  bmem_ready;
   logic [ADDR_WIDTH-1:0] bmem_raddr;
   logic [BEAT_WIDTH-1:0] bmem_rdata;
   logic                  bmem_rvalid;

   modport master (
      output bmem_addr, bmem_read, bmem_write, bmem_wdata,
      input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
   );

   modport slave (
      input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
      output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
   );
endinterface

// File: rtl/bmem_arbiter_line_collector.sv
// Per-requester read tracker: remembers one outstanding line, gathers its beats in order
// and emits a one-cycle response with the finished line.
module bmem_line_collector
   import bmem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int BEAT_WIDTH = bmem_arb_pkg::BEAT_WIDTH,
   parameter int BURST_LEN  = bmem_arb_pkg::BURST_LEN
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_issue,
   input  logic [ADDR_WIDTH-1:0]            i_addr,
   input  logic                             i_rvalid,
   input  logic [ADDR_WIDTH-1:0]            i_raddr,
   input  logic [BEAT_WIDTH-1:0]            i_rdata,
   output logic                             o_out,
   output logic                             o_resp,
   output logic [BEAT_WIDTH*BURST_LEN-1:0]  o_line
);
   localparam int LW    = BEAT_WIDTH * BURST_LEN;
   localparam int CNT_W = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

   logic                              r_out;
   logic                              r_resp;
   logic [ADDR_WIDTH-OFFSET_BITS-1:0] r_tag;
   logic [CNT_W-1:0]                  r_cnt;
   logic [LW-1:0]                     r_asm;
   logic [LW-1:0]                     r_line;
   logic                              w_hit;

   // Once the last beat lands the collector is closed until the flag drops after resp.
   assign w_hit = r_out && !r_resp && i_rvalid &&
                  (i_raddr[ADDR_WIDTH-1:OFFSET_BITS] == r_tag);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out  <= 1'b0;
         r_resp <= 1'b0;
         r_tag  <= '0;
         r_cnt  <= '0;
         r_asm  <= '0;
         r_line <= '0;
      end else begin
         r_resp <= 1'b0;
         if (r_resp) begin
            r_out <= 1'b0;
         end
         if (i_issue) begin
            r_out <= 1'b1;
            r_tag <= i_addr[ADDR_WIDTH-1:OFFSET_BITS];
            r_cnt <= '0;
         end
         if (w_hit) begin
            r_asm[r_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= i_rdata;
            r_cnt <= r_cnt + CNT_W'(1);
            // The output copy only changes on completion so it holds between responses.
            if (r_cnt == LAST) begin
               r_resp <= 1'b1;
               r_line <= {i_rdata, r_asm[LW-BEAT_WIDTH-1:0]};
            end
         end
      end
   end

   assign o_out  = r_out;
   assign o_resp = r_resp;
   assign o_line = r_line;
endmodule

// File: rtl/bmem_arbiter.sv
// Shares one banked-memory port between icache fills and dcache fills/writebacks,
// round-robin arbitrated, with per-requester line assembly of returning bursts.
module bmem_arbiter
   import bmem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int BEAT_WIDTH = bmem_arb_pkg::BEAT_WIDTH,
   parameter int BURST_LEN  = bmem_arb_pkg::BURST_LEN
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [ADDR_WIDTH-1:0]           i_addr,
   input  logic                            i_read,
   output logic [BEAT_WIDTH*BURST_LEN-1:0] i_rdata,
   output logic                            i_resp,
   input  logic [ADDR_WIDTH-1:0]           d_addr,
   input  logic                            d_read,
   input  logic                            d_write,
   input  logic [BEAT_WIDTH*BURST_LEN-1:0] d_wdata,
   output logic [BEAT_WIDTH*BURST_LEN-1:0] d_rdata,
   output logic                            d_resp,
   bmem_arbiter_if.master                  bmem,
   output arb_state_t                      o_dbg_state
);
   localparam int CNT_W = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_WBURST = 1'b1;

   logic [0:0]            r_state;
   logic                  r_rr_d;
   logic [CNT_W-1:0]      r_beat;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic                  r_wr_resp;

   logic w_idle, w_wburst;
   logic w_i_out, w_d_out, w_i_col_resp, w_d_col_resp, w_d_done;
   logic w_i_elig, w_d_elig, w_grant_i, w_grant_d;
   logic w_issue_i, w_issue_d, w_start_wr;
   logic [ADDR_WIDTH-1:0] w_i_line, w_d_line;

   // Combinational strobes are masked while rst is asserted so the pins read 0 in reset.
   assign w_idle   = (r_state == ST_IDLE)   && !rst;
   assign w_wburst = (r_state == ST_WBURST) && !rst;

   assign w_i_line = {i_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   assign w_d_line = {d_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

   assign d_resp   = r_wr_resp | w_d_col_resp;
   assign i_resp   = w_i_col_resp;
   assign w_d_done = d_resp;

   // d_done covers the writeback resp cycle, where no outstanding flag protects the request.
   assign w_i_elig  = i_read && !w_i_out;
   assign w_d_elig  = (d_read || d_write) && !w_d_out && !w_d_done;
   assign w_grant_d = w_d_elig && (!w_i_elig || r_rr_d);
   assign w_grant_i = w_i_elig && !w_grant_d;

   assign w_issue_i  = w_idle && w_grant_i && bmem.bmem_ready;
   assign w_issue_d  = w_idle && w_grant_d && !d_write && bmem.bmem_ready;
   assign w_start_wr = w_idle && w_grant_d && d_write;

   always_comb begin
      bmem.bmem_read  = 1'b0;
      bmem.bmem_write = 1'b0;
      bmem.bmem_addr  = '0;
      bmem.bmem_wdata = '0;
      if (w_idle) begin
         if (w_grant_i) begin
            bmem.bmem_read = 1'b1;
            bmem.bmem_addr = w_i_line;
         end else if (w_grant_d && !d_write) begin
            bmem.bmem_read = 1'b1;
            bmem.bmem_addr = w_d_line;
         end
      end else if (w_wburst) begin
         bmem.bmem_write = 1'b1;
         bmem.bmem_addr  = r_waddr;
         bmem.bmem_wdata = d_wdata[r_beat*BEAT_WIDTH +: BEAT_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_rr_d    <= 1'b1;
         r_beat    <= '0;
         r_waddr   <= '0;
         r_wr_resp <= 1'b0;
      end else begin
         r_wr_resp <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_issue_i || w_issue_d || w_start_wr) begin
                  r_rr_d <= w_grant_i;
               end
               if (w_start_wr) begin
                  r_state <= ST_WBURST;
                  r_beat  <= '0;
                  r_waddr <= w_d_line;
               end
            end
            ST_WBURST: begin
               if (bmem.bmem_ready) begin
                  r_beat <= r_beat + CNT_W'(1);
                  if (r_beat == LAST) begin
                     r_state   <= ST_IDLE;
                     r_wr_resp <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_dbg_state = arb_state_t'(r_state);

   bmem_line_collector #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH),
      .BURST_LEN  (BURST_LEN)
   ) u_icol (
      .clk      (clk),
      .rst      (rst),
      .i_issue  (w_issue_i),
      .i_addr   (i_addr),
      .i_rvalid (bmem.bmem_rvalid),
      .i_raddr  (bmem.bmem_raddr),
      .i_rdata  (bmem.bmem_rdata),
      .o_out    (w_i_out),
      .o_resp   (w_i_col_resp),
      .o_line   (i_rdata)
   );

   bmem_line_collector #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH),
      .BURST_LEN  (BURST_LEN)
   ) u_dcol (
      .clk      (clk),
      .rst      (rst),
      .i_issue  (w_issue_d),
      .i_addr   (d_addr),
      .i_rvalid (bmem.bmem_rvalid),
      .i_raddr  (bmem.bmem_raddr),
      .i_rdata  (bmem.bmem_rdata),
      .o_out    (w_d_out),
      .o_resp   (w_d_col_resp),
      .o_line   (d_rdata)
   );
endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: arbitration, write bursts with stalls, beat routing and reset.
module tb_bmem_arbiter;
   import bmem_arb_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  i_addr = '0;
   logic         i_read = 1'b0;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic [31:0]  d_addr = '0;
   logic         d_read = 1'b0;
   logic         d_write = 1'b0;
   logic [255:0] d_wdata = '0;
   logic [255:0] d_rdata;
   logic         d_resp;
   arb_state_t   dbg_state;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bmem_arbiter_if bif ();

   bmem_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .i_addr      (i_addr),
      .i_read      (i_read),
      .i_rdata     (i_rdata),
      .i_resp      (i_resp),
      .d_addr      (d_addr),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_resp      (d_resp),
      .bmem        (bif),
      .o_dbg_state (dbg_state)
   );

   function automatic logic [63:0] rep(input logic [7:0] b);
      return {8{b}};
   endfunction

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] a, input logic [63:0] d);
      bif.bmem_rvalid = 1'b1;
      bif.bmem_raddr  = a;
      bif.bmem_rdata  = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_addr = 32'h0000_1040;
      i_read = 1'b1;
      bif.bmem_ready = 1'b1;
      tick();
      tick();
      #1;
      tests++; if (bif.bmem_read !== 1'b0) begin fails++; $display("FAIL reset_bmem_read: got %b want 0", bif.bmem_read); end
      tests++; if (bif.bmem_write !== 1'b0) begin fails++; $display("FAIL reset_bmem_write: got %b want 0", bif.bmem_write); end
      tests++; if (bif.bmem_addr !== 32'h0) begin fails++; $display("FAIL reset_bmem_addr: got %h want 0", bif.bmem_addr); end
      tests++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin fails++; $display("FAIL reset_resp: got i=%b d=%b want 0 0", i_resp, d_resp); end
      tests++; if (i_rdata !== '0 || d_rdata !== '0) begin fails++; $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rdata, d_rdata); end
      tests++; if (dbg_state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
      i_read = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_icache_read();
      logic [7:0] b;
      bif.bmem_ready = 1'b1;
      i_addr = 32'h0000_1040;
      i_read = 1'b1;
      #1;
      tests++; if (bif.bmem_read !== 1'b1 || bif.bmem_addr !== 32'h0000_1040) begin fails++; $display("FAIL icache_issue: got read=%b addr=%h want 1 00001040", bif.bmem_read, bif.bmem_addr); end
      tick();
      #1;
      tests++; if (bif.bmem_read !== 1'b0) begin fails++; $display("FAIL icache_single_issue: got read=%b want 0", bif.bmem_read); end
      // A beat for an unrelated line must be dropped.
      beat(32'h0000_9000, rep(8'hEE));
      tick();
      for (int k = 0; k < 4; k++) begin
         b = 8'(8'h11 * (k + 1));
         beat(32'h0000_1040 + 32'(k * 8), rep(b));
         #1;
         tests++; if (i_resp !== 1'b0) begin fails++; $display("FAIL icache_early_resp beat%0d: got %b want 0", k, i_resp); end
         tick();
      end
      bif.bmem_rvalid = 1'b0;
      #1;
      tests++; if (i_resp !== 1'b1) begin fails++; $display("FAIL icache_resp: got %b want 1", i_resp); end
      tests++; if (i_rdata !== {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)}) begin fails++; $display("FAIL icache_rdata: got %h", i_rdata); end
      tests++; if (bif.bmem_read !== 1'b0) begin fails++; $display("FAIL icache_no_reissue: got read=%b want 0", bif.bmem_read); end
      tick();
      i_read = 1'b0;
      #1;
      tests++; if (i_resp !== 1'b0) begin fails++; $display("FAIL icache_resp_pulse: got %b want 0", i_resp); end
      tests++; if (i_rdata !== {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)}) begin fails++; $display("FAIL icache_rdata_hold: got %h", i_rdata); end
   endtask

   task automatic test_rr_interleave();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bif.bmem_ready = 1'b1;
      i_addr = 32'h0000_0100;
      d_addr = 32'h0000_0200;
      i_read = 1'b1;
      d_read = 1'b1;
      #1;
      tests++; if (bif.bmem_read !== 1'b1 || bif.bmem_addr !== 32'h0000_0200) begin fails++; $display("FAIL rr_first_dcache: got read=%b addr=%h want 1 00000200", bif.bmem_read, bif.bmem_addr); end
      tick();
      #1;
      tests++; if (bif.bmem_read !== 1'b1 || bif.bmem_addr !== 32'h0000_0100) begin fails++; $display("FAIL rr_second_icache: got read=%b addr=%h want 1 00000100", bif.bmem_read, bif.bmem_addr); end
      tick();
      #1;
      tests++; if (bif.bmem_read !== 1'b0) begin fails++; $display("FAIL rr_both_outstanding: got read=%b want 0", bif.bmem_read); end
      for (int k = 0; k < 4; k++) begin
         beat(32'h0000_0100 + 32'(k * 8), rep(8'(8'hA0 + k)));
         tick();
         beat(32'h0000_0200 + 32'(k * 8), rep(8'(8'hD0 + k)));
         #1;
         if (k == 3) begin
            tests++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin fails++; $display("FAIL rr_iresp_first: got i=%b d=%b want 1 0", i_resp, d_resp); end
            tests++; if (i_rdata !== {rep(8'hA3), rep(8'hA2), rep(8'hA1), rep(8'hA0)}) begin fails++; $display("FAIL rr_irdata: got %h", i_rdata); end
         end else begin
            tests++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin fails++; $display("FAIL rr_early_resp pair%0d: got i=%b d=%b want 0 0", k, i_resp, d_resp); end
         end
         tick();
      end
      bif.bmem_rvalid = 1'b0;
      i_read = 1'b0;
      #1;
      tests++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin fails++; $display("FAIL rr_dresp: got d=%b i=%b want 1 0", d_resp, i_resp); end
      tests++; if (d_rdata !== {rep(8'hD3), rep(8'hD2), rep(8'hD1), rep(8'hD0)}) begin fails++; $display("FAIL rr_drdata: got %h", d_rdata); end
      tick();
      d_read = 1'b0;
      #1;
      tests++; if (d_resp !== 1'b0) begin fails++; $display("FAIL rr_dresp_pulse: got %b want 0", d_resp); end
   endtask

   task automatic test_write_stall();
      logic rdy_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int   idx_pat [6] = '{0, 1, 1, 2, 3, 3};
      bif.bmem_ready = 1'b1;
      d_addr  = 32'h0000_0300;
      d_wdata = {rep(8'hC3), rep(8'hC2), rep(8'hC1), rep(8'hC0)};
      d_write = 1'b1;
      #1;
      tests++; if (bif.bmem_write !== 1'b0 || bif.bmem_read !== 1'b0) begin fails++; $display("FAIL wr_grant_cycle: got write=%b read=%b want 0 0", bif.bmem_write, bif.bmem_read); end
      tick();
      #1;
      tests++; if (dbg_state !== WBURST) begin fails++; $display("FAIL wr_state: got %0d want WBURST", dbg_state); end
      for (int k = 0; k < 6; k++) begin
         bif.bmem_ready = rdy_pat[k];
         #1;
         tests++; if (bif.bmem_write !== 1'b1 || bif.bmem_addr !== 32'h0000_0300) begin fails++; $display("FAIL wr_strobe cyc%0d: got write=%b addr=%h want 1 00000300", k, bif.bmem_write, bif.bmem_addr); end
         tests++; if (bif.bmem_wdata !== rep(8'(8'hC0 + idx_pat[k]))) begin fails++; $display("FAIL wr_wdata cyc%0d: got %h want beat %0d", k, bif.bmem_wdata, idx_pat[k]); end
         tests++; if (d_resp !== 1'b0) begin fails++; $display("FAIL wr_early_resp cyc%0d: got %b want 0", k, d_resp); end
         tick();
      end
      bif.bmem_ready = 1'b1;
      #1;
      tests++; if (d_resp !== 1'b1) begin fails++; $display("FAIL wr_resp: got %b want 1", d_resp); end
      tests++; if (bif.bmem_write !== 1'b0 || bif.bmem_read !== 1'b0 || dbg_state !== IDLE) begin fails++; $display("FAIL wr_done_blocks: got write=%b read=%b state=%0d want 0 0 IDLE", bif.bmem_write, bif.bmem_read, dbg_state); end
      tick();
      d_write = 1'b0;
      #1;
      tests++; if (d_resp !== 1'b0 || dbg_state !== IDLE) begin fails++; $display("FAIL wr_resp_pulse: got resp=%b state=%0d want 0 IDLE", d_resp, dbg_state); end
   endtask

   task automatic test_read_during_write();
      bif.bmem_ready = 1'b1;
      i_addr = 32'h0000_0500;
      i_read = 1'b1;
      #1;
      tests++; if (bif.bmem_read !== 1'b1 || bif.bmem_addr !== 32'h0000_0500) begin fails++; $display("FAIL rdw_issue: got read=%b addr=%h want 1 00000500", bif.bmem_read, bif.bmem_addr); end
      tick();
      d_addr  = 32'h0000_0600;
      d_wdata = {rep(8'h63), rep(8'h62), rep(8'h61), rep(8'h60)};
      d_write = 1'b1;
      #1;
      tests++; if (bif.bmem_read !== 1'b0 || bif.bmem_write !== 1'b0) begin fails++; $display("FAIL rdw_grant: got read=%b write=%b want 0 0", bif.bmem_read, bif.bmem_write); end
      tick();
      for (int k = 0; k < 4; k++) begin
         beat(32'h0000_0500 + 32'(k * 8), rep(8'(8'h50 + k)));
         #1;
         tests++; if (bif.bmem_write !== 1'b1 || bif.bmem_read !== 1'b0 || bif.bmem_addr !== 32'h0000_0600) begin fails++; $display("FAIL rdw_wburst cyc%0d: got write=%b read=%b addr=%h", k, bif.bmem_write, bif.bmem_read, bif.bmem_addr); end
         tests++; if (bif.bmem_wdata !== rep(8'(8'h60 + k))) begin fails++; $display("FAIL rdw_wdata cyc%0d: got %h want beat %0d", k, bif.bmem_wdata, k); end
         tick();
      end
      bif.bmem_rvalid = 1'b0;
      #1;
      tests++; if (i_resp !== 1'b1 || d_resp !== 1'b1) begin fails++; $display("FAIL rdw_resps: got i=%b d=%b want 1 1", i_resp, d_resp); end
      tests++; if (i_rdata !== {rep(8'h53), rep(8'h52), rep(8'h51), rep(8'h50)}) begin fails++; $display("FAIL rdw_irdata: got %h", i_rdata); end
      tick();
      i_read  = 1'b0;
      d_write = 1'b0;
      #1;
      tests++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin fails++; $display("FAIL rdw_resp_pulse: got i=%b d=%b want 0 0", i_resp, d_resp); end
   endtask

   task automatic test_shared_line();
      logic [255:0] exp_line;
      exp_line = {rep(8'h43), rep(8'h42), rep(8'h41), rep(8'h40)};
      bif.bmem_ready = 1'b1;
      i_addr = 32'h0000_0400;
      d_addr = 32'h0000_0400;
      i_read = 1'b1;
      d_read = 1'b1;
      #1;
      tests++; if (bif.bmem_read !== 1'b1 || bif.bmem_addr !== 32'h0000_0400) begin fails++; $display("FAIL shared_issue1: got read=%b addr=%h", bif.bmem_read, bif.bmem_addr); end
      tick();
      #1;
      tests++; if (bif.bmem_read !== 1'b1 || bif.bmem_addr !== 32'h0000_0400) begin fails++; $display("FAIL shared_issue2: got read=%b addr=%h", bif.bmem_read, bif.bmem_addr); end
      tick();
      for (int k = 0; k < 4; k++) begin
         beat(32'h0000_0400 + 32'(k * 8), rep(8'(8'h40 + k)));
         #1;
         tests++; if (bif.bmem_read !== 1'b0) begin fails++; $display("FAIL shared_no_issue cyc%0d: got read=%b want 0", k, bif.bmem_read); end
         tick();
      end
      bif.bmem_rvalid = 1'b0;
      #1;
      tests++; if (i_resp !== 1'b1 || d_resp !== 1'b1) begin fails++; $display("FAIL shared_resps: got i=%b d=%b want 1 1", i_resp, d_resp); end
      tests++; if (i_rdata !== exp_line || d_rdata !== exp_line) begin fails++; $display("FAIL shared_rdata: got i=%h d=%h", i_rdata, d_rdata); end
      tick();
      i_read = 1'b0;
      d_read = 1'b0;
      #1;
      tests++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin fails++; $display("FAIL shared_resp_pulse: got i=%b d=%b want 0 0", i_resp, d_resp); end
   endtask

   task automatic test_reset_mid_burst();
      bif.bmem_ready = 1'b1;
      i_addr = 32'h0000_0700;
      i_read = 1'b1;
      #1;
      tests++; if (bif.bmem_read !== 1'b1 || bif.bmem_addr !== 32'h0000_0700) begin fails++; $display("FAIL rmb_issue: got read=%b addr=%h", bif.bmem_read, bif.bmem_addr); end
      tick();
      beat(32'h0000_0700, rep(8'h71));
      tick();
      beat(32'h0000_0708, rep(8'h72));
      tick();
      rst = 1'b1;
      i_read = 1'b0;
      beat(32'h0000_0710, rep(8'h73));
      tick();
      rst = 1'b0;
      beat(32'h0000_0718, rep(8'h74));
      #1;
      tests++; if (i_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin fails++; $display("FAIL rmb_outputs: got resp=%b i=%h d=%h want 0", i_resp, i_rdata, d_rdata); end
      tests++; if (bif.bmem_read !== 1'b0 || dbg_state !== IDLE) begin fails++; $display("FAIL rmb_idle: got read=%b state=%0d want 0 IDLE", bif.bmem_read, dbg_state); end
      tick();
      bif.bmem_rvalid = 1'b0;
      #1;
      tests++; if (i_resp !== 1'b0 || i_rdata !== '0) begin fails++; $display("FAIL rmb_beats_ignored: got resp=%b rdata=%h want 0", i_resp, i_rdata); end
      i_read = 1'b1;
      #1;
      tests++; if (bif.bmem_read !== 1'b1 || bif.bmem_addr !== 32'h0000_0700) begin fails++; $display("FAIL rmb_fresh_issue: got read=%b addr=%h", bif.bmem_read, bif.bmem_addr); end
      tick();
      for (int k = 0; k < 4; k++) begin
         beat(32'h0000_0700 + 32'(k * 8), rep(8'(8'h81 + k)));
         #1;
         tests++; if (i_resp !== 1'b0) begin fails++; $display("FAIL rmb_early_resp beat%0d: got %b want 0", k, i_resp); end
         tick();
      end
      bif.bmem_rvalid = 1'b0;
      #1;
      tests++; if (i_resp !== 1'b1) begin fails++; $display("FAIL rmb_fresh_resp: got %b want 1", i_resp); end
      tests++; if (i_rdata !== {rep(8'h84), rep(8'h83), rep(8'h82), rep(8'h81)}) begin fails++; $display("FAIL rmb_fresh_rdata: got %h", i_rdata); end
      tick();
      i_read = 1'b0;
   endtask

   initial begin
      bif.bmem_ready  = 1'b0;
      bif.bmem_raddr  = '0;
      bif.bmem_rdata  = '0;
      bif.bmem_rvalid = 1'b0;
      test_reset();
      test_icache_read();
      test_rr_interleave();
      test_write_stall();
      test_read_during_write();
      test_shared_line();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
